// File: rtl/mips_boot_ctrl_if.sv
// Boot loader bus bundle: program image stream (valid/ready) plus the
// clear/load write ports toward instruction memory, data memory and the
// register bank. The master side is the boot controller.
//
// Handshake: a program word transfers on every rising clk edge where
// prog_valid and prog_ready are both high; prog_data and prog_last are only
// meaningful while prog_valid is high, and prog_ready never depends on
// prog_valid.
interface mips_boot_ctrl_if #(
    parameter int IA = 9,
    parameter int DA = 8
);
    logic          prog_valid;
    logic [31:0]   prog_data;
    logic          prog_last;
    logic          prog_ready;

    logic          imem_we;
    logic [IA-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    logic          dmem_we;
    logic [DA-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;

    logic          rf_we;
    logic [4:0]    rf_addr;
    logic [31:0]   rf_wdata;

    modport master (
        input  prog_valid, prog_data, prog_last,
        output prog_ready,
        output imem_we, imem_addr, imem_wdata,
        output dmem_we, dmem_addr, dmem_wdata,
        output rf_we, rf_addr, rf_wdata
    );

    modport slave (
        output prog_valid, prog_data, prog_last,
        input  prog_ready,
        input  imem_we, imem_addr, imem_wdata,
        input  dmem_we, dmem_addr, dmem_wdata,
        input  rf_we, rf_addr, rf_wdata
    );
endinterface

// File: rtl/mips_boot_ctrl.sv
// Boot sequencer for MIPS_core: holds the core in reset, zeroes imem, dmem
// and the register bank, streams a program image into imem, preloads the
// stack pointer and then releases the core.
module mips_boot_ctrl #(
    parameter int          IMEM_DEPTH = 512,
    parameter int          DMEM_DEPTH = 256,
    parameter int          SP_REG     = 31,
    parameter logic [31:0] SP_INIT    = 32'h1001_0000,
    localparam int         IA         = $clog2(IMEM_DEPTH),
    localparam int         DA         = $clog2(DMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    mips_boot_ctrl_if.master bus,
    output logic            core_rst,
    output logic            busy,
    output logic            done,
    output logic            err_overflow,
    output logic [IA:0]     load_count,
    output logic [2:0]      state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLR     = 3'd1,
        S_LOAD    = 3'd2,
        S_INIT_RF = 3'd3,
        S_RUN     = 3'd4
    } state_t;

    // The clear sweep covers the larger of the two memories; the register
    // bank (32 entries) rides along in the first cycles.
    localparam int            CLR_N    = (IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH;
    localparam int            CW       = $clog2(CLR_N);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_N - 1);
    localparam logic [IA:0]   PTR_LAST = (IA + 1)'(IMEM_DEPTH - 1);
    localparam logic [31:0]   IMEM_N   = 32'(IMEM_DEPTH);
    localparam logic [31:0]   DMEM_N   = 32'(DMEM_DEPTH);
    localparam logic [4:0]    SP_ADDR  = 5'(SP_REG);

    state_t        state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic [IA:0]   load_count_q, load_count_d;
    logic          err_q, err_d;
    // Accepted words are written one cycle after the accept.
    logic          wr_pend_q, wr_pend_d;
    logic [IA-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [31:0]   clr_idx;

    assign clr_idx = 32'(clr_cnt_q);

    // State and datapath registers; reset aborts any boot in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            clr_cnt_q    <= '0;
            load_count_q <= '0;
            err_q        <= 1'b0;
            wr_pend_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            load_count_q <= load_count_d;
            err_q        <= err_d;
            wr_pend_q    <= wr_pend_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // Next-state logic and all write-port outputs.
    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        load_count_d   = load_count_q;
        err_d          = err_q;
        wr_pend_d      = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;

        bus.prog_ready = 1'b0;
        bus.imem_we    = wr_pend_q;
        bus.imem_addr  = wr_pend_q ? wr_addr_q : '0;
        bus.imem_wdata = wr_pend_q ? wr_data_q : '0;
        bus.dmem_we    = 1'b0;
        bus.dmem_addr  = '0;
        bus.dmem_wdata = '0;
        bus.rf_we      = 1'b0;
        bus.rf_addr    = '0;
        bus.rf_wdata   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_CLR;
                    clr_cnt_d    = '0;
                    load_count_d = '0;
                    err_d        = 1'b0;
                end
            end
            S_CLR: begin
                if (clr_idx < IMEM_N) begin
                    bus.imem_we   = 1'b1;
                    bus.imem_addr = IA'(clr_cnt_q);
                end
                if (clr_idx < DMEM_N) begin
                    bus.dmem_we   = 1'b1;
                    bus.dmem_addr = DA'(clr_cnt_q);
                end
                if (clr_idx < 32'd32) begin
                    bus.rf_we   = 1'b1;
                    bus.rf_addr = 5'(clr_cnt_q);
                end
                if (clr_cnt_q == CLR_LAST) begin
                    state_d   = S_LOAD;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_LOAD: begin
                bus.prog_ready = 1'b1;
                if (bus.prog_valid) begin
                    wr_pend_d    = 1'b1;
                    wr_addr_d    = load_count_q[IA-1:0];
                    wr_data_d    = bus.prog_data;
                    load_count_d = load_count_q + 1'b1;
                    if (bus.prog_last) begin
                        state_d = S_INIT_RF;
                    end else if (load_count_q == PTR_LAST) begin
                        // Image does not fit: keep what was written, drop the rest.
                        err_d   = 1'b1;
                        state_d = S_INIT_RF;
                    end
                end
            end
            S_INIT_RF: begin
                bus.rf_we    = 1'b1;
                bus.rf_addr  = SP_ADDR;
                bus.rf_wdata = SP_INIT;
                state_d      = S_RUN;
            end
            S_RUN: begin
                if (start) begin
                    state_d      = S_CLR;
                    clr_cnt_d    = '0;
                    load_count_d = '0;
                    err_d        = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign core_rst     = (state_q != S_RUN);
    assign done         = (state_q == S_RUN);
    assign busy         = (state_q == S_CLR) || (state_q == S_LOAD) || (state_q == S_INIT_RF);
    assign err_overflow = err_q;
    assign load_count   = load_count_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Bench for mips_boot_ctrl: a default-size instance (512/256) and a small
// instance (IMEM_DEPTH=8) for the overflow case.
module tb_mips_boot_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start0 = 1'b0;
    logic        start8 = 1'b0;
    logic        core_rst0, busy0, done0, err0;
    logic [9:0]  lc0;
    logic [2:0]  st0;
    logic        core_rst8, busy8, done8, err8;
    logic [3:0]  lc8;
    logic [2:0]  st8;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int ptr0 = 0;
    int ptr8 = 0;
    int wr_cnt0 = 0;
    int wr_cnt8 = 0;
    bit mon0 = 1'b0;
    bit mon8 = 1'b0;

    logic [40:0] exp0_q[$];
    logic [34:0] exp8_q[$];

    mips_boot_ctrl_if #(.IA(9), .DA(8)) if0 ();
    mips_boot_ctrl_if #(.IA(3), .DA(8)) if8 ();

    mips_boot_ctrl dut0 (
        .clk(clk), .rst(rst), .start(start0), .bus(if0.master),
        .core_rst(core_rst0), .busy(busy0), .done(done0), .err_overflow(err0),
        .load_count(lc0), .state_dbg(st0)
    );

    mips_boot_ctrl #(.IMEM_DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .bus(if8.master),
        .core_rst(core_rst8), .busy(busy8), .done(done8), .err_overflow(err8),
        .load_count(lc8), .state_dbg(st8)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every imem write during a load must match the oldest accepted word
    always @(negedge clk) begin
        if (mon0 && if0.imem_we) begin
            logic [40:0] e;
            wr_cnt0++;
            tests++;
            if (exp0_q.size() == 0) begin
                fails++;
                $display("FAIL imem_write0: got unexpected write addr=%0d data=%h, expected no write",
                         if0.imem_addr, if0.imem_wdata);
            end else begin
                e = exp0_q.pop_front();
                if ({if0.imem_addr, if0.imem_wdata} !== e) begin
                    fails++;
                    $display("FAIL imem_write0: got addr=%0d data=%h, expected addr=%0d data=%h",
                             if0.imem_addr, if0.imem_wdata, e[40:32], e[31:0]);
                end
            end
        end
        if (mon8 && if8.imem_we) begin
            logic [34:0] e8;
            wr_cnt8++;
            tests++;
            if (exp8_q.size() == 0) begin
                fails++;
                $display("FAIL imem_write8: got unexpected write addr=%0d data=%h, expected no write",
                         if8.imem_addr, if8.imem_wdata);
            end else begin
                e8 = exp8_q.pop_front();
                if ({if8.imem_addr, if8.imem_wdata} !== e8) begin
                    fails++;
                    $display("FAIL imem_write8: got addr=%0d data=%h, expected addr=%0d data=%h",
                             if8.imem_addr, if8.imem_wdata, e8[34:32], e8[31:0]);
                end
            end
        end
    end

    // Driver: idle cycles with garbage on data/last (must be ignored)
    task automatic idle(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) begin
                if0.prog_valid = 1'b0; if0.prog_data = $urandom; if0.prog_last = 1'($urandom_range(0, 1));
            end else begin
                if8.prog_valid = 1'b0; if8.prog_data = $urandom; if8.prog_last = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
    endtask

    // Driver: offer one word; on accept push the expected write and return at
    // the negedge after the accepting edge.
    task automatic send_word(input int sel, input logic [31:0] d, input logic l,
                             input int budget, output bit ok);
        logic rdy;
        ok = 1'b0;
        if (sel == 0) begin
            if0.prog_valid = 1'b1; if0.prog_data = d; if0.prog_last = l;
        end else begin
            if8.prog_valid = 1'b1; if8.prog_data = d; if8.prog_last = l;
        end
        for (int k = 0; k < budget; k++) begin
            rdy = (sel == 0) ? if0.prog_ready : if8.prog_ready;
            if (rdy) begin
                if (sel == 0) begin
                    exp0_q.push_back({9'(ptr0), d});
                    ptr0++;
                end else begin
                    exp8_q.push_back({3'(ptr8), d});
                    ptr8++;
                end
                acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        if (sel == 0) begin
            if0.prog_valid = 1'b0; if0.prog_data = $urandom; if0.prog_last = 1'b0;
        end else begin
            if8.prog_valid = 1'b0; if8.prog_data = $urandom; if8.prog_last = 1'b0;
        end
    endtask

    // Called at the negedge of the first CLR cycle of dut0; checks every
    // clear cycle and that LOAD follows after exactly 512 cycles.
    task automatic run_clear(input bit poke);
        for (int c = 0; c < 512; c++) begin
            tests++;
            if ({core_rst0, done0, busy0, if0.prog_ready} !== 4'b1010) begin
                fails++;
                $display("FAIL clr_status c=%0d: got core_rst/done/busy/ready=%b, expected 1010", c,
                         {core_rst0, done0, busy0, if0.prog_ready});
            end
            tests++;
            if ({if0.imem_we, if0.imem_addr, if0.imem_wdata} !== {1'b1, 9'(c), 32'h0}) begin
                fails++;
                $display("FAIL clr_imem c=%0d: got we=%b addr=%0d data=%h, expected we=1 addr=%0d data=0",
                         c, if0.imem_we, if0.imem_addr, if0.imem_wdata, c);
            end
            tests++;
            if ({if0.dmem_we, if0.dmem_addr, if0.dmem_wdata} !==
                ((c < 256) ? {1'b1, 8'(c), 32'h0} : 41'h0)) begin
                fails++;
                $display("FAIL clr_dmem c=%0d: got we=%b addr=%0d, expected we=%0d addr=%0d",
                         c, if0.dmem_we, if0.dmem_addr, (c < 256), (c < 256) ? c : 0);
            end
            tests++;
            if ({if0.rf_we, if0.rf_addr, if0.rf_wdata} !==
                ((c < 32) ? {1'b1, 5'(c), 32'h0} : 38'h0)) begin
                fails++;
                $display("FAIL clr_rf c=%0d: got we=%b addr=%0d, expected we=%0d addr=%0d",
                         c, if0.rf_we, if0.rf_addr, (c < 32), (c < 32) ? c : 0);
            end
            start0 = poke && (c == 100);
            @(negedge clk);
        end
        start0 = 1'b0;
        tests++;
        if ({if0.prog_ready, busy0, st0} !== {1'b1, 1'b1, 3'd2}) begin
            fails++;
            $display("FAIL clr_to_load: got ready=%b busy=%b state=%0d, expected ready=1 busy=1 state=2",
                     if0.prog_ready, busy0, st0);
        end
        mon0 = 1'b1;
        ptr0 = 0;
        wr_cnt0 = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start0 = 1'b1; start8 = 1'b1;
        if0.prog_valid = 1'b0; if0.prog_data = '0; if0.prog_last = 1'b0;
        if8.prog_valid = 1'b0; if8.prog_data = '0; if8.prog_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({core_rst0, if0.prog_ready, done0, busy0, if0.imem_we, if0.dmem_we, if0.rf_we, err0, lc0, st0}
                !== {7'b1000000, 1'b0, 10'd0, 3'd0}) begin
                fails++;
                $display("FAIL reset0: got core_rst=%b ready=%b done=%b busy=%b we=%b%b%b err=%b lc=%0d, expected 1,0,0,0,000,0,0",
                         core_rst0, if0.prog_ready, done0, busy0, if0.imem_we, if0.dmem_we, if0.rf_we, err0, lc0);
            end
            tests++;
            if ({core_rst8, if8.prog_ready, done8, busy8, if8.imem_we, if8.dmem_we, if8.rf_we} !== 7'b1000000) begin
                fails++;
                $display("FAIL reset8: got %b, expected 1000000",
                         {core_rst8, if8.prog_ready, done8, busy8, if8.imem_we, if8.dmem_we, if8.rf_we});
            end
        end
        start0 = 1'b0; start8 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clear_with_start_poke();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        run_clear(1'b1);
    endtask

    task automatic test_load();
        logic [31:0] w [51];
        bit ok;
        w[0] = 32'h0000_0000;
        for (int i = 1; i < 50; i++) w[i] = {6'h08, 5'(i), 5'(i), 16'h0001};
        w[1]  = 32'h2001_0001;
        w[49] = 32'h2231_0001;
        w[50] = 32'h0810_0030;
        for (int i = 0; i < 51; i++) begin
            idle(0, $urandom_range(0, 2));
            send_word(0, w[i], (i == 50), 20, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL load_accept word=%0d: got no accept, expected accept", i);
            end
        end
        // INIT_RF cycle: SP preload and final imem write
        tests++;
        if ({if0.rf_we, if0.rf_addr, if0.rf_wdata, core_rst0, if0.prog_ready} !==
            {1'b1, 5'd31, 32'h1001_0000, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL init_rf: got we=%b addr=%0d data=%h core_rst=%b ready=%b, expected 1,31,10010000,1,0",
                     if0.rf_we, if0.rf_addr, if0.rf_wdata, core_rst0, if0.prog_ready);
        end
        @(negedge clk);
        tests++;
        if ({core_rst0, done0, busy0} !== 3'b010 || (cyc - acc_cyc) != 2) begin
            fails++;
            $display("FAIL release: got core_rst=%b done=%b busy=%b after %0d cycles, expected 0,1,0 after 2",
                     core_rst0, done0, busy0, cyc - acc_cyc);
        end
        tests++;
        if (lc0 !== 10'd51 || err0 !== 1'b0) begin
            fails++;
            $display("FAIL load_count: got lc=%0d err=%b, expected lc=51 err=0", lc0, err0);
        end
        tests++;
        if (wr_cnt0 != 51 || exp0_q.size() != 0) begin
            fails++;
            $display("FAIL load_writes: got %0d writes, %0d pending, expected 51 writes, 0 pending",
                     wr_cnt0, exp0_q.size());
        end
    endtask

    task automatic test_overflow();
        int n;
        int acc;
        bit ok;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!if8.prog_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n != 256) begin
            fails++;
            $display("FAIL ovf_clr_len: got %0d cycles, expected 256", n);
        end
        mon8 = 1'b1;
        ptr8 = 0;
        wr_cnt8 = 0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            send_word(8, $urandom, 1'b0, (i < 8) ? 20 : 5, ok);
            if (ok) acc++;
            if (i == 7) begin
                tests++;
                if ({if8.prog_ready, err8, if8.rf_we} !== 3'b011) begin
                    fails++;
                    $display("FAIL ovf_stop: got ready=%b err=%b rf_we=%b, expected 0,1,1",
                             if8.prog_ready, err8, if8.rf_we);
                end
            end
        end
        tests++;
        if (acc != 8 || wr_cnt8 != 8 || exp8_q.size() != 0) begin
            fails++;
            $display("FAIL ovf_count: got %0d accepts %0d writes, expected 8 accepts 8 writes", acc, wr_cnt8);
        end
        tests++;
        if ({done8, core_rst8, err8, lc8} !== {1'b1, 1'b0, 1'b1, 4'd8}) begin
            fails++;
            $display("FAIL ovf_final: got done=%b core_rst=%b err=%b lc=%0d, expected 1,0,1,8",
                     done8, core_rst8, err8, lc8);
        end
    endtask

    task automatic test_reboot();
        tests++;
        if (done0 !== 1'b1) begin
            fails++;
            $display("FAIL reboot_pre: got done=%b, expected 1", done0);
        end
        mon0 = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        run_clear(1'b0);
    endtask

    task automatic test_abort();
        bit ok;
        for (int i = 0; i < 5; i++) begin
            send_word(0, $urandom, 1'b0, 20, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL abort_accept word=%0d: got no accept, expected accept", i);
            end
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if ({core_rst0, if0.prog_ready, busy0, done0, if0.imem_we, lc0, st0} !==
            {5'b10000, 10'd0, 3'd0}) begin
            fails++;
            $display("FAIL abort_reset: got core_rst=%b ready=%b busy=%b done=%b we=%b lc=%0d state=%0d, expected 1,0,0,0,0,0,0",
                     core_rst0, if0.prog_ready, busy0, done0, if0.imem_we, lc0, st0);
        end
        tests++;
        if (exp0_q.size() != 0 || wr_cnt0 != 5) begin
            fails++;
            $display("FAIL abort_writes: got %0d writes %0d pending, expected 5 writes 0 pending",
                     wr_cnt0, exp0_q.size());
        end
        mon0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({core_rst0, busy0, st0} !== {1'b1, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL abort_idle: got core_rst=%b busy=%b state=%0d, expected 1,0,0", core_rst0, busy0, st0);
        end
    endtask

    task automatic test_restart_single_word();
        bit ok;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        run_clear(1'b0);
        send_word(0, 32'hdead_beef, 1'b1, 20, ok);
        tests++;
        if (!ok || if0.rf_we !== 1'b1 || if0.prog_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_word: got ok=%b rf_we=%b ready=%b, expected 1,1,0", ok, if0.rf_we, if0.prog_ready);
        end
        @(negedge clk);
        tests++;
        if ({done0, core_rst0, lc0, err0} !== {1'b1, 1'b0, 10'd1, 1'b0} || wr_cnt0 != 1) begin
            fails++;
            $display("FAIL single_final: got done=%b core_rst=%b lc=%0d err=%b writes=%0d, expected 1,0,1,0,1",
                     done0, core_rst0, lc0, err0, wr_cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_clear_with_start_poke();
        test_load();
        test_overflow();
        test_reboot();
        test_abort();
        test_restart_single_word();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mips_boot_ctrl.md
Name: mips_boot_ctrl

Overview:
Boot sequencer for MIPS_core. It holds the core in reset and clears instruction memory, data memory and the register bank. It then streams a program image into instruction memory over a valid/ready interface, preloads the stack-pointer register, and releases the core. This replaces backdoor memory initialization with a synthesizable load path.

Parameters:
IMEM_DEPTH, 512, instruction memory words; address width IA = clog2(IMEM_DEPTH)
DMEM_DEPTH, 256, data memory words (matches DATA_MEM_DEPTH); address width DA = clog2(DMEM_DEPTH)
SP_REG, 31, register index preloaded after load
SP_INIT, 32'h10010000, value written to SP_REG

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle boot request
prog_valid  in  1  program word valid
prog_data  in  32  program word
prog_last  in  1  marks final word; qualified by prog_valid
prog_ready  out  1  loader accepts a word
imem_we  out  1  instruction memory write enable
imem_addr  out  IA  instruction memory write address
imem_wdata  out  32  instruction memory write data
dmem_we  out  1  data memory write enable
dmem_addr  out  DA  data memory write address
dmem_wdata  out  32  data memory write data; always 0
rf_we  out  1  register bank write enable
rf_addr  out  5  register index
rf_wdata  out  32  register write data
core_rst  out  1  active-high reset to MIPS_core
busy  out  1  high in CLR, LOAD, INIT_RF
done  out  1  high in RUN
err_overflow  out  1  sticky; image exceeded IMEM_DEPTH
load_count  out  IA+1  words accepted in the last load

Behaviour:
- Reset (rst=0, async): state=IDLE, core_rst=1, all other outputs 0, counters 0. Reset mid-operation aborts immediately; there is no resume.
- States: IDLE, CLR, LOAD, INIT_RF, RUN.
- IDLE: core_rst=1. start=1 -> CLR. Clear err_overflow and load_count.
- CLR:
  - Counter c runs from 0 to max(IMEM_DEPTH, DMEM_DEPTH)-1, one step per cycle.
  - Each cycle: imem_we=1 with addr c and data 0 if c<IMEM_DEPTH; dmem_we=1 with addr c if c<DMEM_DEPTH; rf_we=1 with addr c and data 0 if c<32.
  - After the last count -> LOAD. Duration is exactly max(IMEM_DEPTH, DMEM_DEPTH) cycles.
- LOAD:
  - prog_ready=1. A word is accepted on a cycle with prog_valid & prog_ready.
  - The accepted word is written registered: imem_we=1 on the next cycle, at imem_addr=ptr and imem_wdata=word. ptr starts at 0 and increments per accept; load_count increments per accept.
  - prog_valid may drop at any time; no write occurs without an accept.
  - Accept with prog_last=1 -> INIT_RF, and prog_ready=0 from the next cycle.
  - Accept at ptr=IMEM_DEPTH-1 without prog_last -> err_overflow=1 -> INIT_RF. Later words are not accepted (truncation).
  - prog_data is ignored when prog_valid=0. prog_last on the very first word is legal (1-word image).
- INIT_RF: one cycle with rf_we=1, rf_addr=SP_REG, rf_wdata=SP_INIT; the last imem write completes in this same cycle. -> RUN.
- RUN: core_rst=0, done=1.
- Latency: last accept at cycle T -> INIT_RF at T+1 -> core_rst=0 and done=1 at T+2.
- start is ignored in CLR, LOAD and INIT_RF.
- start in RUN triggers a re-boot: core_rst=1 and done=0 on the next edge, then CLR.
- Write enables are mutually exclusive per memory, except in CLR where all three may be asserted together.

Test Plan:
1. Hold rst=0 for 3 cycles with start=1 -> core_rst=1; prog_ready, done, busy and all write enables stay 0.
2. start pulse with defaults -> 512 CLR cycles; dmem_we on addresses 0..255 only, rf_we on 0..31 only; prog_ready rises on cycle 513.
3. Load 51 words (0x00000000, 0x20010001, ..., 0x22310001, last=0x08100030) with random valid gaps -> imem[0..50] match; load_count=51; rf[31]=0x10010000; core_rst=0 two cycles after the last accept.
4. With IMEM_DEPTH=8, send 10 words without prog_last -> 8 writes (addresses 0..7), err_overflow=1, prog_ready=0 after the 8th accept, core released.
5. Assert rst=0 after 5 words accepted -> core_rst=1 and prog_ready=0 immediately; after rst=1, a new start repeats the full CLR.
6. start during CLR -> no restart, CLR count unchanged. start in RUN -> next cycle core_rst=1, done=0, CLR begins.
